if2_redirect_ctrl: RTL

Sequencing controller for the IF2 pre-decode redirect path. Takes the pre-decoder's per-bundle verdict (branch-taken flag, corrected PC, slot-valid mask) and turns it into a single registered redirect request to the PC generator. It holds that request until the generator accepts it, then squashes the wrong-path bundles still in flight. Backend flushes always win.

---
 rtl/if2_redirect_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/if2_redirect_ctrl.sv
// IF2 pre-decode redirect sequencer: registered redirect request, shadow squash.
// Optional accepted-redirect counter: define IF2_REDIR_STAT_EN to enable.
module if2_redirect_ctrl #(
  parameter int unsigned SHADOW_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        predec_br,
  input  logic [31:0] predec_pc,
  input  logic [1:0]  predec_mask,
  input  logic        if2_valid,
  input  logic        if2_adv,
  input  logic        backend_flush,
  input  logic        pc_ready,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic [1:0]  if2_keep,
  output logic        flush_if1,
  output logic        stall_if,
  output logic [31:0] redir_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SHADOW
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rv_q, rv_d;
  logic [31:0] pc_q, pc_d;
  logic        acc;

  // Redirect accepted from the pre-decoder this cycle
  always_comb begin
    acc = rstn && (state_q == IDLE) && predec_br &&
          if2_valid && if2_adv && !backend_flush;
  end

  // Next-state, request and shadow-counter logic; backend flush overrides
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = REQ;
          rv_d    = 1'b1;
          pc_d    = predec_pc;
        end
      end
      REQ: begin
        if (pc_ready) begin
          state_d = SHADOW;
          rv_d    = 1'b0;
          cnt_d   = 3'(SHADOW_CYCLES);
        end
      end
      SHADOW: begin
        if (if2_adv && if2_valid) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (backend_flush) begin
      state_d = IDLE;
      rv_d    = 1'b0;
      cnt_d   = 3'd0;
    end
  end

  // Combinational keep/kill/freeze controls for the fetch stages
  always_comb begin
    if2_keep  = 2'b00;
    flush_if1 = 1'b0;
    stall_if  = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE: begin
          if (acc)
            if2_keep = predec_mask;
          else if (if2_valid)
            if2_keep = 2'b11;
          flush_if1 = acc;
        end
        REQ: begin
          stall_if  = 1'b1;
          flush_if1 = !backend_flush;
        end
        default: ;
      endcase
      if (backend_flush)
        if2_keep = 2'b00;
    end
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rv_q    <= 1'b0;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      pc_q    <= pc_d;
    end
  end

  assign redir_valid = rv_q;
  assign redir_pc    = pc_q;

`ifdef IF2_REDIR_STAT_EN
  logic [31:0] stat_q, stat_d;

  // Accepted-redirect statistic, wraps naturally
  always_comb begin
    stat_d = stat_q;
    if (acc)
      stat_d = stat_q + 32'd1;
  end

  // Statistic register, cleared by reset only
  always_ff @(posedge clk) begin
    if (!rstn)
      stat_q <= 32'd0;
    else
      stat_q <= stat_d;
  end

  assign redir_cnt = stat_q;
`else
  assign redir_cnt = 32'd0;
`endif

endmodule
